// File: rtl/bf8b_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bf8b_pkg
//  Description : Shared opcode map, sequencer state encoding and decode helper
//                for the eightbit core (used by the sequencer and the ALU).
//  Revision    : 1.0  initial release
// ============================================================================
package bf8b_pkg;

   // Opcode map
   localparam logic [7:0] OP_NOP      = 8'h00;
   localparam logic [7:0] OP_LDA_I    = 8'h01;
   localparam logic [7:0] OP_LDB_I    = 8'h02;
   localparam logic [7:0] OP_LDA_M    = 8'h03;
   localparam logic [7:0] OP_STA      = 8'h04;
   localparam logic [7:0] OP_JMP      = 8'h05;
   localparam logic [7:0] OP_JZ       = 8'h06;
   localparam logic [7:0] OP_ALU_BASE = 8'h10;
   localparam logic [7:0] OP_ALU_LAST = 8'h17;
   localparam logic [7:0] OP_HLT      = 8'hFF;

   // Sequencer states
   typedef enum logic [3:0] {
      S_FETCH = 4'd0,
      S_FWAIT = 4'd1,
      S_DECODE = 4'd2,
      S_OPND  = 4'd3,
      S_OWAIT = 4'd4,
      S_EXEC  = 4'd5,
      S_MWAIT = 4'd6,
      S_WB    = 4'd7,
      S_HALT  = 4'd8
   } seq_state_t;

   // True for opcodes executed by the ALU
   function automatic logic is_alu_op(input logic [7:0] op);
      return (op >= OP_ALU_BASE) && (op <= OP_ALU_LAST);
   endfunction

endpackage : bf8b_pkg
`default_nettype wire

// File: rtl/seq_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seq_decode
//  Description : Combinational opcode classifier for the fetch sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_decode
   import bf8b_pkg::*;
(
   input  logic [7:0] opcode,
   output logic       is_alu,
   output logic       two_byte,
   output logic       is_halt,
   output logic       illegal
);

   logic w_is_nop;

   // Classify the opcode; anything unrecognised is flagged illegal
   always_comb begin
      is_alu   = is_alu_op(opcode);
      two_byte = (opcode >= OP_LDA_I) && (opcode <= OP_JZ);
      is_halt  = (opcode == OP_HLT);
      w_is_nop = (opcode == OP_NOP);
      illegal  = !(w_is_nop || two_byte || is_alu || is_halt);
   end

endmodule : seq_decode
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction fetch/decode/sequence stage of the eightbit core.
//                Owns the PC, drives the memory bus and issues register,
//                store, jump and ALU strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_sequencer
   import bf8b_pkg::*;
#(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   output logic [7:0] addr,
   output logic [7:0] data_out,
   output logic       we,
   input  logic [7:0] a_val,
   output logic [7:0] inst,
   output logic       alu_en,
   output logic       a_we,
   output logic       b_we,
   output logic [7:0] wdata,
   output logic       halted,
   output logic       illegal
);

   seq_state_t r_state;
   seq_state_t w_next_state;
   logic [7:0] r_pc;
   logic [7:0] r_inst;
   logic [7:0] r_operand;
   logic [7:0] r_data_hold;

   logic w_is_alu;
   logic w_two_byte;
   logic w_is_halt;
   logic w_illegal;

   logic [7:0] w_addr;
   logic       w_we;
   logic       w_alu_en;
   logic       w_a_we;
   logic       w_b_we;
   logic       w_illegal_pulse;
   logic       w_halted;

   seq_decode u_decode (
      .opcode   (r_inst),
      .is_alu   (w_is_alu),
      .two_byte (w_two_byte),
      .is_halt  (w_is_halt),
      .illegal  (w_illegal)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and Moore output decode
   always_comb begin
      w_next_state    = r_state;
      w_addr          = r_pc;
      w_we            = 1'b0;
      w_alu_en        = 1'b0;
      w_a_we          = 1'b0;
      w_b_we          = 1'b0;
      w_illegal_pulse = 1'b0;
      w_halted        = 1'b0;
      case (r_state)
         S_FETCH: w_next_state = S_FWAIT;
         S_FWAIT: w_next_state = S_DECODE;
         S_DECODE: begin
            w_alu_en        = w_is_alu;
            w_illegal_pulse = w_illegal;
            if (w_is_halt) begin
               w_next_state = S_HALT;
            end else if (w_two_byte) begin
               w_next_state = S_OPND;
            end else begin
               w_next_state = S_FETCH;
            end
         end
         S_OPND:  w_next_state = S_OWAIT;
         S_OWAIT: w_next_state = S_EXEC;
         S_EXEC: begin
            w_next_state = S_FETCH;
            case (r_inst)
               OP_LDA_I: w_a_we = 1'b1;
               OP_LDB_I: w_b_we = 1'b1;
               OP_LDA_M: begin
                  w_addr       = r_operand;
                  w_next_state = S_MWAIT;
               end
               OP_STA: begin
                  w_addr = r_operand;
                  w_we   = 1'b1;
               end
               default: ;
            endcase
         end
         S_MWAIT: w_next_state = S_WB;
         S_WB: begin
            w_a_we       = 1'b1;
            w_next_state = S_FETCH;
         end
         S_HALT: w_halted = 1'b1;
         default: w_next_state = S_FETCH;
      endcase
   end

   // PC, instruction, operand and store-data registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc        <= RESET_PC;
         r_inst      <= 8'h00;
         r_operand   <= 8'h00;
         r_data_hold <= 8'h00;
      end else begin
         case (r_state)
            S_FWAIT: begin
               r_inst <= data_in;
               r_pc   <= r_pc + 8'h01;
            end
            S_OWAIT: begin
               r_operand <= data_in;
               r_pc      <= r_pc + 8'h01;
            end
            S_EXEC: begin
               if (r_inst == OP_JMP) begin
                  r_pc <= r_operand;
               end else if ((r_inst == OP_JZ) && (a_val == 8'h00)) begin
                  r_pc <= r_operand;
               end else if (r_inst == OP_STA) begin
                  r_data_hold <= a_val;
               end
            end
            S_MWAIT: r_operand <= data_in;
            default: ;
         endcase
      end
   end

   // Strobes are suppressed while reset is asserted so a reset landing in a
   // store or write cycle never reaches memory or the register file.
   always_comb begin
      addr     = w_addr;
      we       = w_we && rst_n;
      alu_en   = w_alu_en && rst_n;
      a_we     = w_a_we && rst_n;
      b_we     = w_b_we && rst_n;
      illegal  = w_illegal_pulse && rst_n;
      halted   = w_halted;
      data_out = (w_we && rst_n) ? a_val : r_data_hold;
      inst     = r_inst;
      wdata    = r_operand;
   end

endmodule : fetch_sequencer
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Directed self-checking bench for fetch_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

   logic       clk;
   logic       rst_n;
   logic [7:0] data_in;
   logic [7:0] addr;
   logic [7:0] data_out;
   logic       we;
   logic [7:0] a_val;
   logic [7:0] inst;
   logic       alu_en;
   logic       a_we;
   logic       b_we;
   logic [7:0] wdata;
   logic       halted;
   logic       illegal;

   logic [7:0] mem [256];
   int tests;
   int fails;

   fetch_sequencer #(.RESET_PC(8'h00)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_in  (data_in),
      .addr     (addr),
      .data_out (data_out),
      .we       (we),
      .a_val    (a_val),
      .inst     (inst),
      .alu_en   (alu_en),
      .a_we     (a_we),
      .b_we     (b_we),
      .wdata    (wdata),
      .halted   (halted),
      .illegal  (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memory with one cycle of read latency
   always @(posedge clk) data_in <= mem[addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   // Leaves the bench observing cycle 1 (FETCH) of the program
   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_val = 8'h00;
      tick();
      tick();
      tests++; if (addr !== 8'h00) begin fails++; $display("FAIL reset_addr got=%h exp=00", addr); end
      tests++; if ({we, alu_en, a_we, b_we, illegal, halted} !== 6'b0) begin
         fails++; $display("FAIL reset_strobes got=%b exp=000000", {we, alu_en, a_we, b_we, illegal, halted});
      end
      tests++; if (inst !== 8'h00 || wdata !== 8'h00 || data_out !== 8'h00) begin
         fails++; $display("FAIL reset_regs inst=%h wdata=%h dout=%h exp=00", inst, wdata, data_out);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_lda_imm();
      int n;
      clear_mem();
      mem[8'h00] = 8'h01; mem[8'h01] = 8'h5A;
      n = 0;
      do_reset();
      for (int c = 1; c <= 7; c++) begin
         if (c == 1) begin tests++; if (addr !== 8'h00) begin fails++; $display("FAIL lda_i_fetch_addr got=%h exp=00", addr); end end
         if (c == 4) begin tests++; if (addr !== 8'h01) begin fails++; $display("FAIL lda_i_opnd_addr got=%h exp=01", addr); end end
         if (c == 6) begin
            tests++; if (a_we !== 1'b1 || wdata !== 8'h5A) begin
               fails++; $display("FAIL lda_i_write a_we=%b wdata=%h exp=1/5a", a_we, wdata);
            end
         end
         if (c == 7) begin tests++; if (addr !== 8'h02) begin fails++; $display("FAIL lda_i_next_fetch got=%h exp=02", addr); end end
         if (a_we === 1'b1) n++;
         if (c < 7) tick();
      end
      tests++; if (n != 1) begin fails++; $display("FAIL lda_i_awe_count got=%0d exp=1", n); end
   endtask

   task automatic test_ldb_alu();
      int n;
      clear_mem();
      mem[8'h00] = 8'h02; mem[8'h01] = 8'h33; mem[8'h02] = 8'h10;
      n = 0;
      do_reset();
      for (int c = 1; c <= 12; c++) begin
         if (c == 6) begin
            tests++; if (b_we !== 1'b1 || wdata !== 8'h33 || a_we !== 1'b0) begin
               fails++; $display("FAIL ldb_write b_we=%b a_we=%b wdata=%h exp=1/0/33", b_we, a_we, wdata);
            end
         end
         if (c == 9) begin
            tests++; if (alu_en !== 1'b1 || inst !== 8'h10) begin
               fails++; $display("FAIL alu_decode alu_en=%b inst=%h exp=1/10", alu_en, inst);
            end
         end
         if (c == 10) begin tests++; if (addr !== 8'h03) begin fails++; $display("FAIL alu_next_fetch got=%h exp=03", addr); end end
         if (c == 11) begin tests++; if (inst !== 8'h10) begin fails++; $display("FAIL alu_inst_hold got=%h exp=10", inst); end end
         if (c == 12) begin tests++; if (inst !== 8'h00) begin fails++; $display("FAIL inst_update got=%h exp=00", inst); end end
         if (alu_en === 1'b1) n++;
         if (c < 12) tick();
      end
      tests++; if (n != 1) begin fails++; $display("FAIL alu_en_count got=%0d exp=1", n); end
   endtask

   task automatic test_sta();
      int n;
      clear_mem();
      mem[8'h00] = 8'h04; mem[8'h01] = 8'h80;
      a_val = 8'h7E;
      n = 0;
      do_reset();
      for (int c = 1; c <= 7; c++) begin
         if (c == 6) begin
            tests++; if (we !== 1'b1 || addr !== 8'h80 || data_out !== 8'h7E) begin
               fails++; $display("FAIL sta_write we=%b addr=%h dout=%h exp=1/80/7e", we, addr, data_out);
            end
         end
         if (c == 7) begin
            a_val = 8'h11;
            #1;
            tests++; if (addr !== 8'h02 || data_out !== 8'h7E) begin
               fails++; $display("FAIL sta_after addr=%h dout=%h exp=02/7e", addr, data_out);
            end
         end
         if (we === 1'b1) n++;
         if (c < 7) tick();
      end
      tests++; if (n != 1) begin fails++; $display("FAIL sta_we_count got=%0d exp=1", n); end
      a_val = 8'h00;
   endtask

   task automatic test_lda_mem();
      int n;
      clear_mem();
      mem[8'h00] = 8'h03; mem[8'h01] = 8'h80; mem[8'h80] = 8'hC4;
      n = 0;
      do_reset();
      for (int c = 1; c <= 9; c++) begin
         if (c == 6) begin tests++; if (addr !== 8'h80) begin fails++; $display("FAIL lda_m_addr got=%h exp=80", addr); end end
         if (c == 8) begin
            tests++; if (a_we !== 1'b1 || wdata !== 8'hC4) begin
               fails++; $display("FAIL lda_m_write a_we=%b wdata=%h exp=1/c4", a_we, wdata);
            end
         end
         if (c == 9) begin tests++; if (addr !== 8'h02) begin fails++; $display("FAIL lda_m_next_fetch got=%h exp=02", addr); end end
         if (a_we === 1'b1) n++;
         if (c < 9) tick();
      end
      tests++; if (n != 1) begin fails++; $display("FAIL lda_m_awe_count got=%0d exp=1", n); end
   endtask

   task automatic test_jz(input logic [7:0] av, input logic [7:0] exp_pc);
      clear_mem();
      mem[8'h00] = 8'h05; mem[8'h01] = 8'h10;
      mem[8'h10] = 8'h06; mem[8'h11] = 8'h40;
      a_val = av;
      do_reset();
      for (int c = 1; c <= 13; c++) begin
         if (c == 7) begin tests++; if (addr !== 8'h10) begin fails++; $display("FAIL jmp_target got=%h exp=10", addr); end end
         if (c == 13) begin
            tests++; if (addr !== exp_pc) begin fails++; $display("FAIL jz_a%h_next got=%h exp=%h", av, addr, exp_pc); end
         end
         if (c < 13) tick();
      end
      a_val = 8'h00;
   endtask

   task automatic test_jmp_wrap();
      clear_mem();
      mem[8'h00] = 8'h05; mem[8'h01] = 8'hFE;
      mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h2B;
      do_reset();
      for (int c = 1; c <= 13; c++) begin
         if (c == 7) begin tests++; if (addr !== 8'hFE) begin fails++; $display("FAIL wrap_fetch got=%h exp=fe", addr); end end
         if (c == 10) begin tests++; if (addr !== 8'hFF) begin fails++; $display("FAIL wrap_opnd got=%h exp=ff", addr); end end
         if (c == 12) begin
            tests++; if (a_we !== 1'b1 || wdata !== 8'h2B) begin
               fails++; $display("FAIL wrap_write a_we=%b wdata=%h exp=1/2b", a_we, wdata);
            end
         end
         if (c == 13) begin tests++; if (addr !== 8'h00) begin fails++; $display("FAIL wrap_next got=%h exp=00", addr); end end
         if (c < 13) tick();
      end
   endtask

   task automatic test_illegal();
      int n;
      int s;
      clear_mem();
      mem[8'h00] = 8'h07;
      n = 0;
      s = 0;
      do_reset();
      for (int c = 1; c <= 4; c++) begin
         if (c == 3) begin tests++; if (illegal !== 1'b1) begin fails++; $display("FAIL illegal_pulse got=%b exp=1", illegal); end end
         if (c == 4) begin tests++; if (addr !== 8'h01) begin fails++; $display("FAIL illegal_next got=%h exp=01", addr); end end
         if (illegal === 1'b1) n++;
         if ({we, alu_en, a_we, b_we} !== 4'b0) s++;
         if (c < 4) tick();
      end
      tests++; if (n != 1 || s != 0) begin fails++; $display("FAIL illegal_counts pulses=%0d strobes=%0d exp=1/0", n, s); end
   endtask

   task automatic test_halt();
      int bad;
      clear_mem();
      mem[8'h00] = 8'hFF;
      bad = 0;
      do_reset();
      tick(); tick(); tick();
      tests++; if (halted !== 1'b1 || addr !== 8'h01) begin
         fails++; $display("FAIL halt_enter halted=%b addr=%h exp=1/01", halted, addr);
      end
      for (int c = 0; c < 20; c++) begin
         tick();
         if (halted !== 1'b1 || addr !== 8'h01 || we !== 1'b0) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL halt_hold bad_cycles=%0d exp=0", bad); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tests++; if (halted !== 1'b0 || addr !== 8'h00) begin
         fails++; $display("FAIL halt_reset halted=%b addr=%h exp=0/00", halted, addr);
      end
   endtask

   task automatic test_reset_mid_store();
      clear_mem();
      mem[8'h00] = 8'h04; mem[8'h01] = 8'h80;
      a_val = 8'h7E;
      do_reset();
      for (int c = 1; c < 6; c++) tick();
      rst_n = 1'b0;
      #1;
      tests++; if (we !== 1'b0) begin fails++; $display("FAIL midstore_we got=%b exp=0", we); end
      tick();
      tests++; if (we !== 1'b0 || addr !== 8'h00 || data_out !== 8'h00 || inst !== 8'h00 || wdata !== 8'h00) begin
         fails++; $display("FAIL midstore_reset we=%b addr=%h dout=%h inst=%h wdata=%h exp=0/00/00/00/00",
                           we, addr, data_out, inst, wdata);
      end
      rst_n = 1'b1;
      a_val = 8'h00;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      a_val = 8'h00;
      clear_mem();
      test_reset();
      test_lda_imm();
      test_ldb_alu();
      test_sta();
      test_lda_mem();
      test_jz(8'h00, 8'h40);
      test_jz(8'h01, 8'h12);
      test_jmp_wrap();
      test_illegal();
      test_halt();
      test_reset_mid_store();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_fetch_sequencer
`default_nettype wire
